imem_boot_ctrl: RTL and testbench

//  Boot sequencer for the RV32I core. Accepts program words on a valid/ready stream and writes

---
 rtl/imem_boot_ctrl.sv | 150 +++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams program words into instruction memory from word 0 upward,
// holding the core in reset until the load completes and a short release delay elapses.
module imem_boot_ctrl #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              halt,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam int              HCW   = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic                err_q, err_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_reset_q, core_reset_d;
    logic                done_q, done_d;
    logic                start_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            hold_cnt_q   <= '0;
            err_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            hold_cnt_q   <= hold_cnt_d;
            err_q        <= err_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        hold_cnt_d   = hold_cnt_q;
        err_d        = err_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        start_req    = 1'b0;

        case (state_q)
            IDLE: begin
                start_req = load_start;
            end
            LOAD: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (s_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q[ADDR_W-1:0];
                    imem_wdata_d = s_data;
                    cnt_d        = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                end else begin
                    start_req = load_start;
                end
            end
            default: state_d = IDLE;
        endcase

        // An oversized request from RUN also stops the core rather than leaving stale code running.
        if (start_req) begin
            if (load_len > DEPTH) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                err_d      = 1'b0;
                len_d      = load_len;
                cnt_d      = '0;
                hold_cnt_d = '0;
                state_d    = (load_len == '0) ? HOLD : LOAD;
            end
        end

        core_reset_d = (state_d != RUN);
        done_d       = (state_d == RUN) && (state_q != RUN);
    end

    assign s_ready    = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == HOLD);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl: loads, gaps, zero/oversize lengths,
// halt/reload in RUN, async reset mid-load and a full-depth load.
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              halt;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] prog [0:7] = '{32'h3e800093, 32'h00300113, 32'h00000193, 32'h00000213,
                                32'h00220863, 32'h001181b3, 32'h00120213, 32'hff5ff36f};

    logic [ADDR_W-1:0] logAddr [$];
    logic [DATA_W-1:0] logData [$];

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_DELAY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .halt       (halt),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write the DUT issues is recorded for later comparison against the program.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logAddr.push_back(imem_addr);
            logData.push_back(imem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] wordFor(input int i);
        if (i < 8) return prog[i];
        return {16'hA5A5, 16'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearLog();
        logAddr.delete();
        logData.delete();
    endtask

    task automatic startLoad(input int len);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic streamWords(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checkOutput("gap_we", imem_we, 0);
                end
            end
            s_valid = 1'b1;
            s_data  = wordFor(i);
            checkOutput("ready_beat", s_ready, 1);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic waitRun(output int cyc);
        cyc = 0;
        do begin
            tick();
            load_start = 1'b0;
            cyc++;
        end while (core_reset === 1'b1 && cyc < 40);
        if (core_reset !== 1'b0) checkOutput("run_timeout", 1, 0);
        else checkOutput("done_pulse", done, 1);
    endtask

    task automatic checkLog(input int n);
        checkOutput("log_len", logAddr.size(), n);
        for (int i = 0; i < n && i < logAddr.size(); i++) begin
            if (logAddr[i] !== ADDR_W'(i)) checkOutput("log_addr", logAddr[i], i);
            if (logData[i] !== wordFor(i)) checkOutput("log_data", logData[i], wordFor(i));
        end
        testsRun++;
    endtask

    task automatic applyStimulus();
        int cyc;

        // Reset state
        checkOutput("rst_core_reset", core_reset, 1);
        checkOutput("rst_we", imem_we, 0);
        checkOutput("rst_addr", imem_addr, 0);
        checkOutput("rst_ready", s_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        reset = 1'b0;
        tick();

        // 1: eight words, continuous stream
        clearLog();
        startLoad(8);
        checkOutput("t1_ready", s_ready, 1);
        checkOutput("t1_busy", busy, 1);
        streamWords(8, 1'b0);
        checkOutput("t1_ready_after", s_ready, 0);
        checkOutput("t1_last_we", imem_we, 1);
        checkOutput("t1_last_addr", imem_addr, 7);
        checkOutput("t1_core_hold", core_reset, 1);
        waitRun(cyc);
        checkOutput("t1_release_cyc", cyc, 2);
        tick();
        checkOutput("t1_done_once", done, 0);
        checkOutput("t1_core_run", core_reset, 0);
        checkLog(8);

        // 2: reload from RUN, gapped stream
        clearLog();
        startLoad(8);
        checkOutput("t2_core_reset", core_reset, 1);
        streamWords(8, 1'b1);
        waitRun(cyc);
        checkLog(8);

        // 3: zero length, oversize, recovery
        clearLog();
        load_start = 1'b1;
        load_len   = '0;
        waitRun(cyc);
        checkOutput("t3_len0_cyc", cyc, 3);
        checkOutput("t3_len0_writes", logAddr.size(), 0);

        // 4a: halt in RUN
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checkOutput("t4_halt_core", core_reset, 1);
        checkOutput("t4_halt_busy", busy, 0);

        startLoad(257);
        checkOutput("t3_err_set", err, 1);
        checkOutput("t3_err_core", core_reset, 1);
        checkOutput("t3_err_idle", busy, 0);
        clearLog();
        startLoad(1);
        checkOutput("t3_err_clear", err, 0);
        streamWords(1, 1'b0);
        waitRun(cyc);
        checkLog(1);

        // 4b: halt and load_start together in RUN
        halt       = 1'b1;
        load_start = 1'b1;
        load_len   = 9'd2;
        tick();
        halt       = 1'b0;
        load_start = 1'b0;
        checkOutput("t4_both_core", core_reset, 1);
        checkOutput("t4_both_ready", s_ready, 0);
        checkOutput("t4_both_busy", busy, 0);
        tick();
        checkOutput("t4_both_ready2", s_ready, 0);

        // 4c: reload of two words from RUN
        load_start = 1'b1;
        load_len   = '0;
        waitRun(cyc);
        clearLog();
        startLoad(2);
        checkOutput("t4_reload_core", core_reset, 1);
        checkOutput("t4_reload_ready", s_ready, 1);
        streamWords(2, 1'b0);
        waitRun(cyc);
        checkLog(2);

        // 5: async reset after three of eight words
        startLoad(8);
        streamWords(3, 1'b0);
        s_valid = 1'b1;
        s_data  = wordFor(3);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_we", imem_we, 0);
        checkOutput("t5_addr", imem_addr, 0);
        checkOutput("t5_wdata", imem_wdata, 0);
        checkOutput("t5_core", core_reset, 1);
        checkOutput("t5_ready", s_ready, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        clearLog();
        startLoad(8);
        streamWords(8, 1'b0);
        waitRun(cyc);
        checkLog(8);

        // 6: full-depth load
        halt = 1'b1;
        tick();
        halt = 1'b0;
        clearLog();
        startLoad(256);
        streamWords(256, 1'b0);
        checkOutput("t6_ready_after", s_ready, 0);
        waitRun(cyc);
        for (int i = 0; i < 4; i++) tick();
        checkLog(256);
        if (logAddr.size() > 0) checkOutput("t6_last_addr", logAddr[logAddr.size()-1], 255);
        else checkOutput("t6_last_addr", 0, 255);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        halt       = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        @(negedge clk);
        @(negedge clk);
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
